// File: rtl/control_sequencer.sv
// Microsequencer: owns the T-state counter and decodes IR0 into bus master/slave IDs, PC increment, ALU drive and halt.
// Latency: outputs are combinational from the current T-state and IR; one T-state per clock unless stalled.
// Backpressure: mem_ready=0 holds any T-state that touches memory, with pc_inr suppressed until the advancing cycle.
module control_sequencer #(
    parameter int T_STATES     = 8,
    parameter int ID_WIDTH     = 3,
    parameter int AMID_WIDTH   = 2,
    parameter int ALU_OP_WIDTH = 5,
    parameter int MEM_ID       = 1,
    parameter int Z_BIT        = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              ir,
    input  logic [3:0]              status,
    input  logic                    mem_ready,
    input  logic                    hlt_req,
    input  logic                    resume,
    output logic [T_STATES-1:0]     t_state,
    output logic [ID_WIDTH-1:0]     mid,
    output logic [ID_WIDTH-1:0]     sid,
    output logic                    mid_en,
    output logic                    sid_en,
    output logic [AMID_WIDTH-1:0]   amid,
    output logic                    pc_inr,
    output logic                    alu_oe,
    output logic [ALU_OP_WIDTH-1:0] alu_opcode,
    output logic                    halted,
    output logic                    illegal
);

    localparam int TW = (T_STATES > 1) ? $clog2(T_STATES) : 1;
    typedef logic [TW-1:0] tcnt_t;

    localparam tcnt_t T0 = tcnt_t'(0);
    localparam tcnt_t T1 = tcnt_t'(1);
    localparam tcnt_t T2 = tcnt_t'(2);
    localparam tcnt_t T3 = tcnt_t'(3);
    localparam tcnt_t T4 = tcnt_t'(4);

    localparam logic [ID_WIDTH-1:0] ID_MEM = ID_WIDTH'(MEM_ID);
    localparam logic [ID_WIDTH-1:0] ID_IR0 = ID_WIDTH'(0);
    localparam logic [ID_WIDTH-1:0] ID_A   = ID_WIDTH'(2);
    localparam logic [ID_WIDTH-1:0] ID_AR0 = ID_WIDTH'(4);
    localparam logic [ID_WIDTH-1:0] ID_AR1 = ID_WIDTH'(5);
    localparam logic [ID_WIDTH-1:0] ID_PC0 = ID_WIDTH'(6);
    localparam logic [ID_WIDTH-1:0] ID_PC1 = ID_WIDTH'(7);

    localparam logic [AMID_WIDTH-1:0] AMID_PC = AMID_WIDTH'(0);
    localparam logic [AMID_WIDTH-1:0] AMID_AR = AMID_WIDTH'(1);

    if (T_STATES < 5) begin : g_chk_tstates
        $error("control_sequencer: T_STATES must be at least 5");
    end
    if (ALU_OP_WIDTH > 6) begin : g_chk_aluop
        $error("control_sequencer: ALU_OP_WIDTH must not exceed 6");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_EXT_HALT
    } state_t;

    state_t state, state_d;
    tcnt_t  t_cnt, t_cnt_d;
    logic   stall;

    // ---------------------------------------------------------------
    // IR decode
    // ---------------------------------------------------------------
    logic [1:0]          op_type;
    logic [5:0]          sys_fn;
    logic [ID_WIDTH-1:0] ir_mid;
    logic [ID_WIDTH-1:0] ir_sid;
    logic                is_mvi, is_alu, is_sys;
    logic                mvi_mid_mem, mvi_sid_mem;
    logic                op_illegal, op_hlt, op_jmp, op_jz;
    logic                unused_status;

    assign op_type     = ir[7:6];
    assign sys_fn      = ir[5:0];
    assign ir_mid      = ID_WIDTH'(ir[5:3]);
    assign ir_sid      = ID_WIDTH'(ir[2:0]);
    assign is_mvi      = (op_type == 2'b00);
    assign is_alu      = (op_type == 2'b01);
    assign is_sys      = (op_type == 2'b10);
    assign mvi_mid_mem = (ir_mid == ID_MEM);
    assign mvi_sid_mem = (ir_sid == ID_MEM);
    assign op_hlt      = is_sys && (sys_fn == 6'd1);
    assign op_jmp      = is_sys && (sys_fn == 6'd2);
    assign op_jz       = is_sys && (sys_fn == 6'd3);

    // A memory-to-memory move has no single bus transfer, so it is rejected.
    assign op_illegal  = (op_type == 2'b11)
                      || (is_sys && (sys_fn > 6'd3))
                      || (is_mvi && mvi_mid_mem && mvi_sid_mem);

    assign unused_status = ^status;

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            t_cnt   <= T0;
            illegal <= 1'b0;
        end else begin
            state <= state_d;
            t_cnt <= t_cnt_d;
            if ((state == ST_RUN) && (t_cnt == T1) && op_illegal) begin
                illegal <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    logic end_instr;

    always_comb begin
        state_d   = state;
        t_cnt_d   = t_cnt;
        end_instr = 1'b0;
        case (state)
            ST_IDLE: begin
                state_d = ST_RUN;
                t_cnt_d = T0;
            end
            ST_RUN: begin
                if (!stall) begin
                    case (t_cnt)
                        T0: t_cnt_d = T1;
                        T1: begin
                            // A HLT releases straight into fetch; external halt requests are not honoured here.
                            if (op_hlt) begin
                                if (resume) begin
                                    t_cnt_d = T0;
                                end
                            end else if (op_jmp || op_jz) begin
                                t_cnt_d = T2;
                            end else begin
                                end_instr = 1'b1;
                            end
                        end
                        T2: begin
                            if (op_jz && !status[Z_BIT]) begin
                                end_instr = 1'b1;
                            end else begin
                                t_cnt_d = T3;
                            end
                        end
                        T3:      t_cnt_d = T4;
                        T4:      end_instr = 1'b1;
                        default: t_cnt_d = T0;
                    endcase
                end
            end
            ST_EXT_HALT: begin
                if (!hlt_req) begin
                    state_d = ST_RUN;
                    t_cnt_d = T0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                t_cnt_d = T0;
            end
        endcase

        if (end_instr) begin
            t_cnt_d = T0;
            if (hlt_req) begin
                state_d = ST_EXT_HALT;
            end
        end
    end

    // ---------------------------------------------------------------
    // Output decode
    // ---------------------------------------------------------------
    logic pc_base;
    logic mem_access;

    always_comb begin
        t_state    = '0;
        mid        = '0;
        sid        = '0;
        mid_en     = 1'b0;
        sid_en     = 1'b0;
        amid       = AMID_PC;
        pc_base    = 1'b0;
        alu_oe     = 1'b0;
        alu_opcode = '0;
        halted     = 1'b0;
        mem_access = 1'b0;
        stall      = 1'b0;
        pc_inr     = 1'b0;

        if ((state != ST_IDLE) && is_alu) begin
            alu_opcode = ir[ALU_OP_WIDTH-1:0];
        end

        if (state == ST_EXT_HALT) begin
            halted = 1'b1;
        end

        if (state == ST_RUN) begin
            t_state = T_STATES'(1) << t_cnt;
            case (t_cnt)
                T0: begin
                    mid     = ID_MEM;
                    sid     = ID_IR0;
                    mid_en  = 1'b1;
                    sid_en  = 1'b1;
                    pc_base = 1'b1;
                end
                T1: begin
                    if (op_illegal) begin
                        // executes as a NOP
                    end else if (is_mvi) begin
                        mid     = ir_mid;
                        sid     = ir_sid;
                        mid_en  = 1'b1;
                        sid_en  = 1'b1;
                        amid    = mvi_sid_mem ? AMID_AR : AMID_PC;
                        pc_base = mvi_mid_mem;
                    end else if (is_alu) begin
                        alu_oe = 1'b1;
                        sid    = ID_A;
                        sid_en = 1'b1;
                    end else if (op_hlt) begin
                        halted = 1'b1;
                    end else if (op_jmp || op_jz) begin
                        mid     = ID_MEM;
                        sid     = ID_AR0;
                        mid_en  = 1'b1;
                        sid_en  = 1'b1;
                        pc_base = 1'b1;
                    end
                end
                T2: begin
                    mid     = ID_MEM;
                    sid     = ID_AR1;
                    mid_en  = 1'b1;
                    sid_en  = 1'b1;
                    pc_base = 1'b1;
                end
                T3: begin
                    mid    = ID_AR0;
                    sid    = ID_PC0;
                    mid_en = 1'b1;
                    sid_en = 1'b1;
                    amid   = AMID_AR;
                end
                T4: begin
                    mid    = ID_AR1;
                    sid    = ID_PC1;
                    mid_en = 1'b1;
                    sid_en = 1'b1;
                    amid   = AMID_AR;
                end
                default: begin
                    t_state = '0;
                end
            endcase
        end

        mem_access = (mid_en && (mid == ID_MEM)) || (sid_en && (sid == ID_MEM));
        stall      = mem_access && !mem_ready;
        pc_inr     = pc_base && !stall;
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: stimulus pushes per-cycle expected outputs, a negedge monitor pops and compares.
module tb_control_sequencer;

    logic       clk;
    logic       reset;
    logic [7:0] ir;
    logic [3:0] status;
    logic       mem_ready;
    logic       hlt_req;
    logic       resume;
    logic [7:0] t_state;
    logic [2:0] mid;
    logic [2:0] sid;
    logic       mid_en;
    logic       sid_en;
    logic [1:0] amid;
    logic       pc_inr;
    logic       alu_oe;
    logic [4:0] alu_opcode;
    logic       halted;
    logic       illegal;

    control_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .ir         (ir),
        .status     (status),
        .mem_ready  (mem_ready),
        .hlt_req    (hlt_req),
        .resume     (resume),
        .t_state    (t_state),
        .mid        (mid),
        .sid        (sid),
        .mid_en     (mid_en),
        .sid_en     (sid_en),
        .amid       (amid),
        .pc_inr     (pc_inr),
        .alu_oe     (alu_oe),
        .alu_opcode (alu_opcode),
        .halted     (halted),
        .illegal    (illegal)
    );

    typedef struct packed {
        logic [7:0] t;
        logic [2:0] mid;
        logic [2:0] sid;
        logic       men;
        logic       sen;
        logic [1:0] amid;
        logic       pc;
        logic       aoe;
        logic [4:0] op;
        logic       hlt;
        logic       ill;
    } exp_t;

    exp_t sbq[$];
    exp_t e_m;
    exp_t a_m;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_no   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input int t, input int m, input int s, input int me, input int se,
                                input int am, input int pc, input int ao, input int op, input int h, input int il);
        exp_t e;
        e.t    = (t < 0) ? 8'h00 : (8'h01 << t);
        e.mid  = 3'(m);
        e.sid  = 3'(s);
        e.men  = 1'(me);
        e.sen  = 1'(se);
        e.amid = 2'(am);
        e.pc   = 1'(pc);
        e.aoe  = 1'(ao);
        e.op   = 5'(op);
        e.hlt  = 1'(h);
        e.ill  = 1'(il);
        return e;
    endfunction

    // Fetch cycle with the given ALU opcode and sticky illegal value.
    function automatic exp_t fetch(input int op, input int il);
        return mk(0, 1, 0, 1, 1, 0, 1, 0, op, 0, il);
    endfunction

    // All-quiet outputs (reset/idle) with the given sticky illegal value.
    function automatic exp_t quiet(input int il);
        return mk(-1, 0, 0, 0, 0, 0, 0, 0, 0, 0, il);
    endfunction

    task automatic cyc(input logic r, input logic [7:0] i, input logic [3:0] s, input logic mr,
                       input logic hr, input logic rs, input exp_t e);
        @(posedge clk);
        #1;
        reset     = r;
        ir        = i;
        status    = s;
        mem_ready = mr;
        hlt_req   = hr;
        resume    = rs;
        sbq.push_back(e);
    endtask

    task automatic go(input logic [7:0] i, input exp_t e);
        cyc(1'b1, i, 4'h0, 1'b1, 1'b0, 1'b0, e);
    endtask

    always @(negedge clk) begin
        cyc_no++;
        if (sbq.size() != 0) begin
            e_m = sbq.pop_front();
            a_m = {t_state, mid, sid, mid_en, sid_en, amid, pc_inr, alu_oe, alu_opcode, halted, illegal};
            n_checks++;
            if (a_m !== e_m) begin
                n_fail++;
                $display("FAIL outputs cycle %0d: got t=%h mid=%0d sid=%0d en=%b%b amid=%0d pc=%b aoe=%b op=%h hlt=%b ill=%b, want t=%h mid=%0d sid=%0d en=%b%b amid=%0d pc=%b aoe=%b op=%h hlt=%b ill=%b",
                         cyc_no, a_m.t, a_m.mid, a_m.sid, a_m.men, a_m.sen, a_m.amid, a_m.pc, a_m.aoe, a_m.op, a_m.hlt, a_m.ill,
                         e_m.t, e_m.mid, e_m.sid, e_m.men, e_m.sen, e_m.amid, e_m.pc, e_m.aoe, e_m.op, e_m.hlt, e_m.ill);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        ir        = 8'h00;
        status    = 4'h0;
        mem_ready = 1'b1;
        hlt_req   = 1'b0;
        resume    = 1'b0;

        // Reset and release: idle one cycle, then fetch.
        cyc(1'b0, 8'h0A, 4'h0, 1'b1, 1'b0, 1'b0, quiet(0));
        cyc(1'b0, 8'h0A, 4'h0, 1'b1, 1'b0, 1'b0, quiet(0));
        cyc(1'b1, 8'h0A, 4'h0, 1'b1, 1'b0, 1'b0, quiet(0));

        // MVI immediate load, store, mixed IDs, register-register.
        go(8'h0A, fetch(0, 0));
        go(8'h0A, mk(1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0));
        go(8'h11, fetch(0, 0));
        go(8'h11, mk(1, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0));
        go(8'h21, fetch(0, 0));
        go(8'h21, mk(1, 4, 1, 1, 1, 1, 0, 0, 0, 0, 0));
        go(8'h1A, fetch(0, 0));
        go(8'h1A, mk(1, 3, 2, 1, 1, 0, 0, 0, 0, 0, 0));

        // NOP with a stalled fetch.
        cyc(1'b1, 8'h80, 4'h0, 1'b0, 1'b0, 1'b0, mk(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        go(8'h80, fetch(0, 0));
        go(8'h80, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // JMP with two wait cycles at T1.
        go(8'h82, fetch(0, 0));
        cyc(1'b1, 8'h82, 4'h0, 1'b0, 1'b0, 1'b0, mk(1, 1, 4, 1, 1, 0, 0, 0, 0, 0, 0));
        cyc(1'b1, 8'h82, 4'h0, 1'b0, 1'b0, 1'b0, mk(1, 1, 4, 1, 1, 0, 0, 0, 0, 0, 0));
        go(8'h82, mk(1, 1, 4, 1, 1, 0, 1, 0, 0, 0, 0));
        go(8'h82, mk(2, 1, 5, 1, 1, 0, 1, 0, 0, 0, 0));
        go(8'h82, mk(3, 4, 6, 1, 1, 1, 0, 0, 0, 0, 0));
        go(8'h82, mk(4, 5, 7, 1, 1, 1, 0, 0, 0, 0, 0));

        // JZ not taken (Z=0 at T2), then taken (Z=1 at T2, cleared later).
        go(8'h83, fetch(0, 0));
        go(8'h83, mk(1, 1, 4, 1, 1, 0, 1, 0, 0, 0, 0));
        go(8'h83, mk(2, 1, 5, 1, 1, 0, 1, 0, 0, 0, 0));
        go(8'h83, fetch(0, 0));
        cyc(1'b1, 8'h83, 4'h1, 1'b1, 1'b0, 1'b0, mk(1, 1, 4, 1, 1, 0, 1, 0, 0, 0, 0));
        cyc(1'b1, 8'h83, 4'h1, 1'b1, 1'b0, 1'b0, mk(2, 1, 5, 1, 1, 0, 1, 0, 0, 0, 0));
        cyc(1'b1, 8'h83, 4'h0, 1'b1, 1'b0, 1'b0, mk(3, 4, 6, 1, 1, 1, 0, 0, 0, 0, 0));
        cyc(1'b1, 8'h83, 4'h0, 1'b1, 1'b0, 1'b0, mk(4, 5, 7, 1, 1, 1, 0, 0, 0, 0, 0));

        // ALU operations.
        go(8'h45, fetch(5, 0));
        go(8'h45, mk(1, 0, 2, 0, 1, 0, 0, 1, 5, 0, 0));
        go(8'h7F, fetch(31, 0));
        go(8'h7F, mk(1, 0, 2, 0, 1, 0, 0, 1, 31, 0, 0));

        // HLT holds T1 for 10 cycles; hlt_req is ignored meanwhile.
        go(8'h81, fetch(0, 0));
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 8'h81, 4'h0, 1'b1, (i >= 3 && i <= 5), 1'b0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        end
        cyc(1'b1, 8'h81, 4'h0, 1'b1, 1'b0, 1'b1, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        go(8'h80, fetch(0, 0));
        go(8'h80, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // External halt request at the end of an ALU op.
        go(8'h45, fetch(5, 0));
        cyc(1'b1, 8'h45, 4'h0, 1'b1, 1'b1, 1'b0, mk(1, 0, 2, 0, 1, 0, 0, 1, 5, 0, 0));
        cyc(1'b1, 8'h80, 4'h0, 1'b1, 1'b1, 1'b0, mk(-1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        cyc(1'b1, 8'h80, 4'h0, 1'b1, 1'b1, 1'b0, mk(-1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        cyc(1'b1, 8'h80, 4'h0, 1'b1, 1'b0, 1'b0, mk(-1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        go(8'h80, fetch(0, 0));
        go(8'h80, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset in the middle of a JMP aborts at once.
        go(8'h82, fetch(0, 0));
        go(8'h82, mk(1, 1, 4, 1, 1, 0, 1, 0, 0, 0, 0));
        go(8'h82, mk(2, 1, 5, 1, 1, 0, 1, 0, 0, 0, 0));
        cyc(1'b0, 8'h82, 4'h0, 1'b1, 1'b0, 1'b0, quiet(0));
        cyc(1'b1, 8'h09, 4'h0, 1'b1, 1'b0, 1'b0, quiet(0));

        // MVI MEM->MEM is illegal and sticks.
        go(8'h09, fetch(0, 0));
        go(8'h09, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        go(8'h80, fetch(0, 1));
        go(8'h80, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

        // Unknown SYS function.
        cyc(1'b0, 8'h84, 4'h0, 1'b1, 1'b0, 1'b0, quiet(0));
        cyc(1'b1, 8'h84, 4'h0, 1'b1, 1'b0, 1'b0, quiet(0));
        go(8'h84, fetch(0, 0));
        go(8'h84, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        go(8'h80, fetch(0, 1));
        go(8'h80, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

        // Type 11 opcode; flag survives later instructions, clears on reset.
        cyc(1'b0, 8'hC0, 4'h0, 1'b1, 1'b0, 1'b0, quiet(0));
        cyc(1'b1, 8'hC0, 4'h0, 1'b1, 1'b0, 1'b0, quiet(0));
        go(8'hC0, fetch(0, 0));
        go(8'hC0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        go(8'h0A, fetch(0, 1));
        go(8'h0A, mk(1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 1));
        cyc(1'b0, 8'h80, 4'h0, 1'b1, 1'b0, 1'b0, quiet(0));

        @(negedge clk);
        #1;
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: %0d entries left, want 0", sbq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
